// File: rtl/game_timebase_ctrl_if.sv
// Control and status bundle between the game logic and the timebase controller.
// The master side drives start/pause/level; the controller (slave) drives the strobes and phase status.
interface game_timebase_ctrl_if;
  logic       start;
  logic       pause;
  logic [1:0] level;
  logic       scan_tick;
  logic       sec_tick;
  logic       mole_tick;
  logic [1:0] state;
  logic [7:0] secs_left;
  logic       round_done;

  modport master (
    output start, pause, level,
    input  scan_tick, sec_tick, mole_tick, state, secs_left, round_done
  );

  modport slave (
    input  start, pause, level,
    output scan_tick, sec_tick, mole_tick, state, secs_left, round_done
  );
endinterface

// File: rtl/game_timebase_ctrl.sv
// Single-clock timebase for the whack-a-mole game: clock-enable strobes (scan, second, mole)
// plus the IDLE -> READY -> PLAY -> OVER phase sequencer with a seconds-remaining counter.
module game_timebase_ctrl #(
  parameter int unsigned TICK_DIV      = 50_000_000,
  parameter int unsigned SCAN_DIV      = 50_000,
  parameter int unsigned MOLE_BASE_DIV = 25_000_000,
  parameter int unsigned READY_SECS    = 3,
  parameter int unsigned ROUND_SECS    = 60
) (
  input  logic                 clk,
  input  logic                 rst_n,
  game_timebase_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READY = 2'd1,
    PLAY  = 2'd2,
    OVER  = 2'd3
  } state_e;

  state_e      state_q;
  logic [7:0]  secs_q;
  logic        round_done_q;
  logic [31:0] scan_cnt;
  logic [31:0] sec_cnt;
  logic [31:0] mole_cnt;

  logic [31:0] mole_lim;
  logic        sec_run;
  logic        mole_run;
  logic        scan_tick;
  logic        sec_tick;
  logic        mole_tick;

  // Strobes are decoded from registered counters/state, gated by the live pause level.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no latch can be inferred.
    mole_lim  = 32'(MOLE_BASE_DIV) >> bus.level;
    sec_run   = 1'b0;
    mole_run  = 1'b0;
    scan_tick = 1'b0;
    sec_tick  = 1'b0;
    mole_tick = 1'b0;

    sec_run   = ((state_q == READY) || (state_q == PLAY)) && !bus.pause;
    mole_run  = (state_q == PLAY) && !bus.pause;
    scan_tick = (scan_cnt == 32'(SCAN_DIV - 1));
    sec_tick  = sec_run && (sec_cnt == 32'(TICK_DIV - 1));
    // >= so that a level increase mid-count fires on the very next evaluation.
    mole_tick = mole_run && (mole_cnt >= (mole_lim - 32'd1));
  end

  // Display scan prescaler is free-running in every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      scan_cnt <= scan_tick ? '0 : scan_cnt + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      secs_q       <= '0;
      round_done_q <= 1'b0;
      sec_cnt      <= '0;
      mole_cnt     <= '0;
    end else begin
      round_done_q <= 1'b0;

      if (sec_run)  sec_cnt  <= sec_tick  ? '0 : sec_cnt  + 32'd1;
      if (mole_run) mole_cnt <= mole_tick ? '0 : mole_cnt + 32'd1;

      // Phase changes below override the counter updates above where they clear them.
      unique case (state_q)
        IDLE, OVER: begin
          if (bus.start) begin
            state_q <= READY;
            secs_q  <= 8'(READY_SECS);
            sec_cnt <= '0;
          end
        end
        READY: begin
          if (sec_tick) begin
            if (secs_q == 8'd1) begin
              state_q  <= PLAY;
              secs_q   <= 8'(ROUND_SECS);
              sec_cnt  <= '0;
              mole_cnt <= '0;
            end else begin
              secs_q <= secs_q - 8'd1;
            end
          end
        end
        PLAY: begin
          if (sec_tick) begin
            if (secs_q == 8'd1) begin
              state_q      <= OVER;
              secs_q       <= '0;
              round_done_q <= 1'b1;
            end else begin
              secs_q <= secs_q - 8'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.scan_tick  = scan_tick;
  assign bus.sec_tick   = sec_tick;
  assign bus.mole_tick  = mole_tick;
  assign bus.state      = state_q;
  assign bus.secs_left  = secs_q;
  assign bus.round_done = round_done_q;

endmodule
